dcache_traffic_gen: RTL

Parametrised, self-checking Dcache stimulus generator and checker. Drives write and read requests onto the Dcache CPU-side port with pseudo-random LFSR data, then compares the returned read data against regenerated expected values. Supports an interleaved write/read mode and a burst mode (all writes, then all reads), a stall handshake and a configurable read latency. Reports pass/fail and error statistics. Sits in the Dcache testbench in place of the CPU model and drives the Dcache directly.

---
 rtl/dcache_tg_pkg.sv | 21 ++
 rtl/dcache_tg_lfsr.sv | 39 +++
 rtl/dcache_traffic_gen.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dcache_tg_pkg.sv
// Shared types and helpers for the Dcache traffic generator.
// Holds the FSM state enum, the LFSR polynomial and its step function.
package dcache_tg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_WAIT,
        S_CHK,
        S_DONE
    } tg_state_e;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/dcache_tg_lfsr.sv
// Seedable 32-bit Galois LFSR; a zero seed is replaced by 1.
// Ports: clk_i, rst_ni (async, active-low), load_i, advance_i, value_o.
module dcache_tg_lfsr
    import dcache_tg_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        advance_i,
    output logic [31:0] value_o
);

    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED_EFF;
        end else if (advance_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/dcache_traffic_gen.sv
// Dcache CPU-port stimulus generator and read-back checker.
// Ports: clk, rst (async, active-low), start_i, mode_i, dcache_stall_i,
//   dcache_data_i; request outputs dcache_{r,w}addr_o, dcache_wdata_o,
//   dcache_{w,r}req_o, dcache_wsel_o; status busy_o, done_o, pass_o,
//   err_cnt_o, first_err_addr_o.
// Option: DCACHE_TG_STOP_ON_ERR_EN ends the run at the first mismatch.
module dcache_traffic_gen
    import dcache_tg_pkg::*;
#(
    parameter int unsigned NUM_WORDS   = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned ADDR_STRIDE = 4,
    parameter int unsigned RD_LAT      = 1,
    parameter logic [31:0] SEED        = 32'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        mode_i,
    input  logic        dcache_stall_i,
    input  logic [31:0] dcache_data_i,
    output logic [31:0] dcache_raddr_o,
    output logic [31:0] dcache_waddr_o,
    output logic [31:0] dcache_wdata_o,
    output logic        dcache_wreq_o,
    output logic        dcache_rreq_o,
    output logic [3:0]  dcache_wsel_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [15:0] err_cnt_o,
    output logic [31:0] first_err_addr_o
);

    localparam int IDX_W  = $clog2(NUM_WORDS + 1);
    localparam int WAIT_W = $clog2(RD_LAT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    tg_state_e         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WAIT_W-1:0] wcnt_q, wcnt_d;
    logic              mode_q, mode_d;
    logic [15:0]       err_q, err_d;
    logic [31:0]       ferr_q, ferr_d;

    logic        lfsr_load;
    logic        lfsr_adv;
    logic [31:0] lfsr_val;
    logic [31:0] addr;
    logic        mismatch;

    assign addr     = BASE_ADDR + 32'(idx_q) * ADDR_STRIDE;
    assign mismatch = (dcache_data_i != lfsr_val);

    dcache_tg_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .clk_i    (clk),
        .rst_ni   (rst),
        .load_i   (lfsr_load),
        .advance_i(lfsr_adv),
        .value_o  (lfsr_val)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wcnt_q  <= '0;
            mode_q  <= 1'b0;
            err_q   <= '0;
            ferr_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wcnt_d    = wcnt_q;
        mode_d    = mode_q;
        err_d     = err_q;
        ferr_d    = ferr_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d   = S_WR;
                    idx_d     = '0;
                    mode_d    = mode_i;
                    err_d     = '0;
                    ferr_d    = '0;
                    lfsr_load = 1'b1;
                end
            end
            S_WR: begin
                if (!dcache_stall_i) begin
                    if (!mode_q) begin
                        state_d = S_RD;
                    end else if (idx_q == LAST_IDX) begin
                        // Burst read phase replays the sequence from SEED.
                        state_d   = S_RD;
                        idx_d     = '0;
                        lfsr_load = 1'b1;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        lfsr_adv = 1'b1;
                    end
                end
            end
            S_RD: begin
                if (!dcache_stall_i) begin
                    wcnt_d  = '0;
                    state_d = (RD_LAT > 1) ? S_WAIT : S_CHK;
                end
            end
            S_WAIT: begin
                if (wcnt_q == WAIT_LAST) begin
                    state_d = S_CHK;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_CHK: begin
                lfsr_adv = 1'b1;
                if (mismatch) begin
                    if (err_q != 16'hFFFF) begin
                        err_d = err_q + 16'd1;
                    end
                    if (err_q == 16'h0) begin
                        ferr_d = addr;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = mode_q ? S_RD : S_WR;
                end
`ifdef DCACHE_TG_STOP_ON_ERR_EN
                if (mismatch) begin
                    state_d = S_DONE;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dcache_wreq_o    = (state_q == S_WR);
        dcache_rreq_o    = (state_q == S_RD);
        dcache_waddr_o   = dcache_wreq_o ? addr : 32'h0;
        dcache_raddr_o   = dcache_rreq_o ? addr : 32'h0;
        dcache_wdata_o   = dcache_wreq_o ? lfsr_val : 32'h0;
        dcache_wsel_o    = dcache_wreq_o ? 4'hF : 4'h0;
        busy_o           = (state_q == S_WR) || (state_q == S_RD) ||
                           (state_q == S_WAIT) || (state_q == S_CHK);
        done_o           = (state_q == S_DONE);
        pass_o           = done_o && (err_q == 16'h0);
        err_cnt_o        = err_q;
        first_err_addr_o = ferr_q;
    end

`ifdef DCACHE_TG_STOP_ON_ERR_EN
`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (state_q == S_CHK && mismatch) begin
            $display("dcache_tg: stopping, mismatch at idx %0d addr %h",
                     idx_q, addr);
        end
    end
`endif
`endif

endmodule
